alu_exec_unit: RTL and testbench
================================

// Module: alu_exec_unit
// PURPOSE
//  Execute stage directly downstream of the operand latches: consumes the latched
//  16-bit operand pair (op1 = accumulator operand, op2 = second register operand)
//  plus an opcode, produces a 16-bit result and ZNCV flags for write-back.
//  Single-cycle logic/arith ops; iterative 16-cycle shift-add multiply.
//  Valid/ready handshake on both sides so the control unit can stall on MUL.
// PARAMETERS
//  WIDTH     16  operand/result width (only 16 is verified)
//  MUL_ITERS 16  multiply iterations; equals WIDTH
// PORTS
//  clk        in   1      single clock, all state on rising edge
//  rst_n      in   1      asynchronous, active-low reset
//  in_valid   in   1      operands+opcode presented
//  in_ready   out  1      unit can accept (high only in IDLE)
//  opcode     in   4      operation select, sampled at accept
//  op1        in   16     operand 1 (accumulator), sampled at accept
//  op2        in   16     operand 2, sampled at accept
//  out_valid  out  1      result/flags valid
//  out_ready  in   1      consumer takes result
//  result     out  16     result word
//  flags      out  4      {Z,N,C,V}
//  illegal    out  1      opcode undefined; valid with out_valid
// BEHAVIOUR
//  Reset (async assert, sync release): state=IDLE, in_ready=1 after release,
//   out_valid=0, result=0, flags=0, illegal=0, internal regs=0. Reset during MUL
//   or while holding a result abandons it; no output is produced.
//  Accept: in_valid & in_ready on a rising edge latches opcode/op1/op2.
//  FSM: IDLE -> EXEC (non-MUL) | MUL (opcode 8).  EXEC -> DONE next edge.
//   MUL: iterates 16 edges, then DONE.  DONE: out_valid=1; out_valid & out_ready
//   -> IDLE. Result/flags held stable in DONE until taken.
//  Latency accept->out_valid: non-MUL 2 cycles; MUL 17 cycles.
//  No new accept while busy (in_ready=0 in EXEC/MUL/DONE); no bypass from DONE.
//  Opcodes: 0 ADD op1+op2 | 1 SUB op1-op2 | 2 AND | 3 OR | 4 XOR | 5 NOT op1 |
//   6 SHL op1<<op2[3:0] | 7 SHR logical op1>>op2[3:0] | 8 MUL low16(op1*op2) |
//   9 PASS op2 | 10-15 illegal: result=0, flags=0 except Z=1, illegal=1.
//  Arithmetic: unsigned 17-bit internal sum; wrap to 16 bits.
//  Flags: Z=(result==0); N=result[15];
//   C: ADD carry-out; SUB borrow (1 when op1<op2 unsigned); SHL/SHR last bit
//      shifted out, 0 when shift amount 0; MUL 1 when product[31:16]!=0; else 0.
//   V: ADD/SUB two's-complement overflow; else 0.
//  MUL: shift-add over op2 bits LSB-first, 32-bit accumulator; op2=0 or op1=0
//   still takes full 16 iterations (fixed latency).
// STRUCTURE
//  Package cpu_alu_pkg: opcode localparams (OP_ADD..OP_PASS), FSM state encoding
//   (IDLE,EXEC,MUL,DONE), flag bit indices (F_Z=3,F_N=2,F_C=1,F_V=0).
//  Sub-module mul_shift_add: start/done iterative multiplier, 16x16->32, 16 cycles;
//   top instantiates it and owns handshake FSM and combinational ALU.
// TESTING
//  ADD 0xFFFF+0x0001 -> result 0x0000, flags Z=1 N=0 C=1 V=0, out_valid 2 cyc after accept
//  SUB 0x8000-0x0001 -> result 0x7FFF, Z=0 N=0 C=0 V=1; SUB 0x0001-0x0002 -> 0xFFFF, N=1 C=1
//  MUL 0x0100*0x0100 -> result 0x0000, Z=1 C=1; MUL 0x0003*0x0005 -> 0x000F, C=0; 17-cycle latency
//  Backpressure: out_ready=0 for 5 cycles after SHL 0x8001<<1 -> result 0x0002 C=1 held stable,
//   in_ready=0 throughout; take -> in_ready=1 next cycle
//  Reset asserted at MUL iteration 7 -> out_valid=0, result=0 immediately; post-release
//   ADD 2+3 -> 0x0005 with no stale output
//  Opcode 0xC with in_valid held high while busy -> exactly one accept, illegal=1, result=0, Z=1

Source files
------------

// File: rtl/cpu_alu_pkg.sv
// Shared definitions for the ALU execute stage: opcodes, FSM states, flag positions.
package cpu_alu_pkg;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned OPC_W  = 4;
    localparam int unsigned FLAG_W = 4;

    localparam logic [OPC_W-1:0] OP_ADD  = 4'd0;
    localparam logic [OPC_W-1:0] OP_SUB  = 4'd1;
    localparam logic [OPC_W-1:0] OP_AND  = 4'd2;
    localparam logic [OPC_W-1:0] OP_OR   = 4'd3;
    localparam logic [OPC_W-1:0] OP_XOR  = 4'd4;
    localparam logic [OPC_W-1:0] OP_NOT  = 4'd5;
    localparam logic [OPC_W-1:0] OP_SHL  = 4'd6;
    localparam logic [OPC_W-1:0] OP_SHR  = 4'd7;
    localparam logic [OPC_W-1:0] OP_MUL  = 4'd8;
    localparam logic [OPC_W-1:0] OP_PASS = 4'd9;

    // Bit positions inside the {Z,N,C,V} flag word
    localparam int unsigned F_Z = 3;
    localparam int unsigned F_N = 2;
    localparam int unsigned F_C = 1;
    localparam int unsigned F_V = 0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        MUL  = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/mul_shift_add.sv
// Iterative shift-add multiplier: start loads operands, ITERS edges later the product is ready.
module mul_shift_add #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned ITERS = WIDTH
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               done_c,
    output logic [2*WIDTH-1:0] product_c
);

    localparam int unsigned PW    = 2 * WIDTH;
    localparam int unsigned CNT_W = (ITERS > 1) ? $clog2(ITERS) : 1;

    logic [PW-1:0]    mcand;
    logic [PW-1:0]    acc;
    logic [WIDTH-1:0] mplier;
    logic [CNT_W-1:0] cnt;
    logic             busy;

    // Value the accumulator takes on this edge; final product when done_c is high
    assign product_c = acc + (mplier[0] ? mcand : PW'(0));
    assign done_c    = busy && (cnt == CNT_W'(ITERS - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand  <= '0;
            acc    <= '0;
            mplier <= '0;
            cnt    <= '0;
            busy   <= 1'b0;
        end else if (start) begin
            mcand  <= PW'(a);
            acc    <= '0;
            mplier <= b;
            cnt    <= '0;
            busy   <= 1'b1;
        end else if (busy) begin
            acc    <= product_c;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + CNT_W'(1);
            if (done_c) begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_exec_unit.sv
// Execute stage: latches operands on accept, runs a single-cycle ALU op or the
// iterative multiplier, and holds result/flags until the consumer takes them.
module alu_exec_unit
    import cpu_alu_pkg::*;
#(
    parameter int unsigned WIDTH     = DATA_W,
    parameter int unsigned MUL_ITERS = WIDTH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OPC_W-1:0]  opcode,
    input  logic [WIDTH-1:0]  op1,
    input  logic [WIDTH-1:0]  op2,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  result,
    output logic [FLAG_W-1:0] flags,
    output logic              illegal
);

    localparam int unsigned SH_W = $clog2(WIDTH);
    localparam int unsigned PW   = 2 * WIDTH;

    state_t state_q;
    state_t state_d;

    logic [OPC_W-1:0]  opc_q;
    logic [WIDTH-1:0]  a_q;
    logic [WIDTH-1:0]  b_q;

    logic              accept_c;
    logic              mul_start_c;
    logic              mul_done_c;
    logic [PW-1:0]     mul_prod_c;
    logic [FLAG_W-1:0] mul_flags_c;

    logic [WIDTH:0]    sum_c;
    logic [WIDTH:0]    diff_c;
    logic [SH_W-1:0]   amt_c;
    logic [PW-1:0]     shl_c;
    logic [PW-1:0]     shr_c;

    logic [WIDTH-1:0]  alu_res_c;
    logic              alu_carry_c;
    logic              alu_ovf_c;
    logic              alu_ill_c;
    logic [FLAG_W-1:0] alu_flags_c;

    logic              load_c;
    logic [WIDTH-1:0]  res_d;
    logic [FLAG_W-1:0] flags_d;
    logic              ill_d;

    assign accept_c    = in_valid && in_ready;
    assign mul_start_c = accept_c && (opcode == OP_MUL);

    mul_shift_add #(
        .WIDTH (WIDTH),
        .ITERS (MUL_ITERS)
    ) u_mul (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (mul_start_c),
        .a         (op1),
        .b         (op2),
        .done_c    (mul_done_c),
        .product_c (mul_prod_c)
    );

    // Shifts are done in a double-width field so the last bit shifted out lands at a fixed index
    assign sum_c  = {1'b0, a_q} + {1'b0, b_q};
    assign diff_c = {1'b0, a_q} - {1'b0, b_q};
    assign amt_c  = b_q[SH_W-1:0];
    assign shl_c  = {{WIDTH{1'b0}}, a_q} << amt_c;
    assign shr_c  = {a_q, {WIDTH{1'b0}}} >> amt_c;

    always_comb begin
        alu_res_c   = '0;
        alu_carry_c = 1'b0;
        alu_ovf_c   = 1'b0;
        alu_ill_c   = 1'b0;
        case (opc_q)
            OP_ADD: begin
                alu_res_c   = sum_c[WIDTH-1:0];
                alu_carry_c = sum_c[WIDTH];
                alu_ovf_c   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum_c[WIDTH-1] != a_q[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res_c   = diff_c[WIDTH-1:0];
                alu_carry_c = diff_c[WIDTH];
                alu_ovf_c   = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (diff_c[WIDTH-1] != a_q[WIDTH-1]);
            end
            OP_AND:  alu_res_c = a_q & b_q;
            OP_OR:   alu_res_c = a_q | b_q;
            OP_XOR:  alu_res_c = a_q ^ b_q;
            OP_NOT:  alu_res_c = ~a_q;
            OP_SHL: begin
                alu_res_c   = shl_c[WIDTH-1:0];
                alu_carry_c = shl_c[WIDTH];
            end
            OP_SHR: begin
                alu_res_c   = shr_c[PW-1:WIDTH];
                alu_carry_c = shr_c[WIDTH-1];
            end
            OP_PASS: alu_res_c = b_q;
            OP_MUL:  alu_res_c = '0;
            default: alu_ill_c = 1'b1;
        endcase
    end

    always_comb begin
        alu_flags_c        = '0;
        alu_flags_c[F_Z]   = (alu_res_c == '0);
        alu_flags_c[F_N]   = alu_res_c[WIDTH-1];
        alu_flags_c[F_C]   = alu_carry_c;
        alu_flags_c[F_V]   = alu_ovf_c;
        mul_flags_c        = '0;
        mul_flags_c[F_Z]   = (mul_prod_c[WIDTH-1:0] == '0);
        mul_flags_c[F_N]   = mul_prod_c[WIDTH-1];
        mul_flags_c[F_C]   = (mul_prod_c[PW-1:WIDTH] != '0);
    end

    // Handshake FSM; also picks which datapath feeds the output registers
    always_comb begin
        state_d = state_q;
        load_c  = 1'b0;
        res_d   = alu_ill_c ? '0 : alu_res_c;
        flags_d = alu_ill_c ? FLAG_W'(1 << F_Z) : alu_flags_c;
        ill_d   = alu_ill_c;
        case (state_q)
            IDLE: begin
                if (accept_c) begin
                    state_d = (opcode == OP_MUL) ? MUL : EXEC;
                end
            end
            EXEC: begin
                state_d = DONE;
                load_c  = 1'b1;
            end
            MUL: begin
                if (mul_done_c) begin
                    state_d = DONE;
                    load_c  = 1'b1;
                    res_d   = mul_prod_c[WIDTH-1:0];
                    flags_d = mul_flags_c;
                    ill_d   = 1'b0;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            state_q   <= state_d;
            in_ready  <= (state_d == IDLE);
            out_valid <= (state_d == DONE);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opc_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            result  <= '0;
            flags   <= '0;
            illegal <= 1'b0;
        end else begin
            if (accept_c) begin
                opc_q <= opcode;
                a_q   <= op1;
                b_q   <= op2;
            end
            if (load_c) begin
                result  <= res_d;
                flags   <= flags_d;
                illegal <= ill_d;
            end
        end
    end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Scoreboard bench for alu_exec_unit: directed vectors with hand-computed results.
module tb_alu_exec_unit;
    import cpu_alu_pkg::*;

    logic        clk       = 1'b0;
    logic        rst_n     = 1'b0;
    logic        in_valid  = 1'b0;
    logic        out_ready = 1'b1;
    logic [3:0]  opcode    = '0;
    logic [15:0] op1       = '0;
    logic [15:0] op2       = '0;
    logic        in_ready;
    logic        out_valid;
    logic [15:0] result;
    logic [3:0]  flags;
    logic        illegal;

    always #5 clk = ~clk;

    alu_exec_unit dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .opcode    (opcode),
        .op1       (op1),
        .op2       (op2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .flags     (flags),
        .illegal   (illegal)
    );

    typedef struct {
        logic [15:0] r;
        logic [3:0]  f;
        logic        ill;
        int          lat;
        int          acc_cyc;
        string       name;
    } exp_t;

    exp_t q[$];
    exp_t cur;
    bit   presented = 1'b0;
    int   cyc       = 0;
    int   acc_count = 0;
    int   total     = 0;
    int   bad       = 0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst_n && in_valid && in_ready) acc_count <= acc_count + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        total++;
        bad++;
        $display("FAIL %s: got timeout/unexpected expected none", name);
    endtask

    // Monitor: pops on first presentation, then checks the held value until taken
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && out_valid) begin
                if (!presented) begin
                    if (q.size() == 0) begin
                        fail_now("unexpected_output");
                    end else begin
                        cur = q.pop_front();
                        presented = 1'b1;
                        check({cur.name, "_result"},  32'(result),  32'(cur.r));
                        check({cur.name, "_flags"},   32'(flags),   32'(cur.f));
                        check({cur.name, "_illegal"}, 32'(illegal), 32'(cur.ill));
                        check({cur.name, "_latency"}, 32'(cyc - cur.acc_cyc), 32'(cur.lat));
                    end
                end else begin
                    check({cur.name, "_hold_result"}, 32'(result), 32'(cur.r));
                    check({cur.name, "_hold_flags"},  32'(flags),  32'(cur.f));
                    check({cur.name, "_hold_in_ready"}, 32'(in_ready), 32'd0);
                end
                if (out_ready) presented = 1'b0;
            end
        end
    end

    task automatic issue(input string name, input logic [3:0] opc, input logic [15:0] a,
                         input logic [15:0] b, input logic [15:0] r, input logic [3:0] f,
                         input logic ill, input int lat, input bit hold);
        exp_t e;
        int   guard;
        @(posedge clk); #2;
        opcode   = opc;
        op1      = a;
        op2      = b;
        in_valid = 1'b1;
        guard    = 0;
        while (!in_ready && guard < 200) begin
            @(posedge clk); #2;
            guard++;
        end
        if (!in_ready) begin
            fail_now({name, "_accept_timeout"});
            in_valid = 1'b0;
            return;
        end
        e.r       = r;
        e.f       = f;
        e.ill     = ill;
        e.lat     = lat;
        e.acc_cyc = cyc;
        e.name    = name;
        q.push_back(e);
        @(posedge clk); #2;
        if (!hold) in_valid = 1'b0;
    endtask

    task automatic wait_out_valid(input string name);
        int guard = 0;
        while (!out_valid && guard < 100) begin
            @(posedge clk); #2;
            guard++;
        end
        if (!out_valid) fail_now({name, "_out_valid_timeout"});
    endtask

    task automatic wait_idle();
        int guard = 0;
        while ((q.size() != 0 || out_valid || !in_ready) && guard < 200) begin
            @(posedge clk); #2;
            guard++;
        end
        if (guard >= 200) fail_now("idle_timeout");
    endtask

    initial begin
        int acc_before;

        #12;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_result",    32'(result),    32'd0);
        check("rst_flags",     32'(flags),     32'd0);
        check("rst_illegal",   32'(illegal),   32'd0);
        #10 rst_n = 1'b1;
        @(posedge clk); #2;
        check("rst_in_ready",  32'(in_ready),  32'd1);

        // name, opcode, op1, op2, result, {Z,N,C,V}, illegal, latency, hold
        issue("add_wrap",   OP_ADD,  16'hFFFF, 16'h0001, 16'h0000, 4'b1010, 1'b0, 2, 1'b0);
        issue("sub_ovf",    OP_SUB,  16'h8000, 16'h0001, 16'h7FFF, 4'b0001, 1'b0, 2, 1'b0);
        issue("sub_borrow", OP_SUB,  16'h0001, 16'h0002, 16'hFFFF, 4'b0110, 1'b0, 2, 1'b0);
        issue("add_ovf",    OP_ADD,  16'h7FFF, 16'h0001, 16'h8000, 4'b0101, 1'b0, 2, 1'b0);
        issue("and",        OP_AND,  16'hF0F0, 16'h0FF0, 16'h00F0, 4'b0000, 1'b0, 2, 1'b0);
        issue("or",         OP_OR,   16'h0F00, 16'h00F0, 16'h0FF0, 4'b0000, 1'b0, 2, 1'b0);
        issue("xor",        OP_XOR,  16'hAAAA, 16'hAAAA, 16'h0000, 4'b1000, 1'b0, 2, 1'b0);
        issue("not",        OP_NOT,  16'h00FF, 16'h1234, 16'hFF00, 4'b0100, 1'b0, 2, 1'b0);
        issue("shl_amt0",   OP_SHL,  16'h1234, 16'h0010, 16'h1234, 4'b0000, 1'b0, 2, 1'b0);
        issue("shl_15",     OP_SHL,  16'h0001, 16'h000F, 16'h8000, 4'b0100, 1'b0, 2, 1'b0);
        issue("shr_1",      OP_SHR,  16'h000F, 16'h0001, 16'h0007, 4'b0010, 1'b0, 2, 1'b0);
        issue("shr_15",     OP_SHR,  16'h8000, 16'h000F, 16'h0001, 4'b0000, 1'b0, 2, 1'b0);
        issue("pass",       OP_PASS, 16'h1111, 16'h8000, 16'h8000, 4'b0100, 1'b0, 2, 1'b0);
        issue("mul_carry",  OP_MUL,  16'h0100, 16'h0100, 16'h0000, 4'b1010, 1'b0, 17, 1'b0);
        issue("mul_small",  OP_MUL,  16'h0003, 16'h0005, 16'h000F, 4'b0000, 1'b0, 17, 1'b0);
        issue("mul_zero",   OP_MUL,  16'hFFFF, 16'h0000, 16'h0000, 4'b1000, 1'b0, 17, 1'b0);
        issue("mul_ff",     OP_MUL,  16'h00FF, 16'h00FF, 16'hFE01, 4'b0100, 1'b0, 17, 1'b0);
        wait_idle();

        // Backpressure: result must stay put while the consumer stalls
        out_ready = 1'b0;
        issue("shl_bp", OP_SHL, 16'h8001, 16'h0001, 16'h0002, 4'b0010, 1'b0, 2, 1'b0);
        wait_out_valid("shl_bp");
        repeat (5) @(posedge clk);
        #2;
        out_ready = 1'b1;
        @(posedge clk); #2;
        check("bp_in_ready_after_take", 32'(in_ready),  32'd1);
        check("bp_out_valid_after_take", 32'(out_valid), 32'd0);
        wait_idle();

        // Illegal opcode with in_valid held high while busy
        acc_before = acc_count;
        issue("illegal_c", 4'hC, 16'h1234, 16'h5678, 16'h0000, 4'b1000, 1'b1, 2, 1'b1);
        wait_out_valid("illegal_c");
        in_valid = 1'b0;
        wait_idle();
        repeat (3) @(posedge clk);
        #2;
        check("illegal_accept_count", 32'(acc_count - acc_before), 32'd1);

        // Reset in the middle of a multiply, after leaving a nonzero result behind
        issue("pass_pre", OP_PASS, 16'h0000, 16'hBEEF, 16'hBEEF, 4'b0100, 1'b0, 2, 1'b0);
        wait_idle();
        issue("mul_abort", OP_MUL, 16'h1234, 16'h0002, 16'h2468, 4'b0000, 1'b0, 17, 1'b0);
        repeat (7) @(posedge clk);
        #3;
        check("mul_busy_in_ready", 32'(in_ready), 32'd0);
        rst_n = 1'b0;
        #1;
        check("abort_out_valid", 32'(out_valid), 32'd0);
        check("abort_result",    32'(result),    32'd0);
        check("abort_flags",     32'(flags),     32'd0);
        q.delete();
        presented = 1'b0;
        #7 rst_n = 1'b1;
        issue("add_post_rst", OP_ADD, 16'h0002, 16'h0003, 16'h0005, 4'b0000, 1'b0, 2, 1'b0);
        wait_idle();
        repeat (20) @(posedge clk);
        #2;
        check("queue_empty", 32'(q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
